// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a runtime-loadable pattern and don't-care mask.
// Supports overlapping and non-overlapping matches and keeps a saturating match counter.
module seq_detect_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [PAT_W-1:0] pat_mask,
  input  logic             overlap_en,
  input  logic             count_clr,
  output logic             armed,
  output logic             outFlag,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  state_t             state_q;
  logic [PAT_W-1:0]   window_q;
  logic [PAT_W-1:0]   pattern_q;
  logic [PAT_W-1:0]   mask_q;
  logic [FILL_W-1:0]  fill_q;
  logic               out_flag_q;
  logic [CNT_W-1:0]   count_q;
  logic               count_sat_q;

  logic [PAT_W-1:0]   window_d;
  logic [CNT_W-1:0]   count_d;
  logic               shift_en;
  logic               full_d;
  logic               match_d;

  // A load takes precedence over the bit presented in the same cycle.
  assign window_d = {window_q[PAT_W-2:0], bit_in};
  assign shift_en = bit_valid && !pat_load && (state_q != IDLE);
  assign full_d   = (state_q == HUNT) || (fill_q == FILL_W'(PAT_W - 1));
  assign match_d  = shift_en && full_d &&
                    ((~(window_d ^ pattern_q) & mask_q) == mask_q);

  always_comb begin
    count_d = count_q;
    if (count_clr) begin
      count_d = '0;
    end else if (match_d && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      window_q    <= '0;
      fill_q      <= '0;
      pattern_q   <= '0;
      mask_q      <= '0;
      out_flag_q  <= 1'b0;
      count_q     <= '0;
      count_sat_q <= 1'b0;
    end else begin
      out_flag_q  <= match_d;
      count_q     <= count_d;
      count_sat_q <= &count_d;
      if (pat_load) begin
        pattern_q <= pat_in;
        mask_q    <= pat_mask;
        window_q  <= '0;
        fill_q    <= '0;
        state_q   <= FILL;
      end else if (shift_en) begin
        window_q <= window_d;
        if (match_d && !overlap_en) begin
          // Non-overlapping: demand a completely fresh pattern's worth of bits.
          state_q <= FILL;
          fill_q  <= '0;
        end else if (state_q == FILL) begin
          fill_q <= fill_q + FILL_W'(1);
          if (full_d) begin
            state_q <= HUNT;
          end
        end
      end
    end
  end

  assign armed       = (state_q != IDLE);
  assign outFlag     = out_flag_q;
  assign match_count = count_q;
  assign count_sat   = count_sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a behavioural model pushes expected outputs per cycle,
// popped and compared after each edge; two instances cover the 8-bit and 2-bit counter widths.
module tb_seq_detect_param;

  logic       clock;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic       pat_load;
  logic [3:0] pat_in;
  logic [3:0] pat_mask;
  logic       overlap_en;
  logic       count_clr;

  logic       armed8, flag8, sat8;
  logic [7:0] cnt8;
  logic       armed2, flag2, sat2;
  logic [1:0] cnt2;

  int n_vec = 0;
  int n_err = 0;

  seq_detect_param #(.PAT_W(4), .CNT_W(8)) u8 (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .pat_load(pat_load), .pat_in(pat_in), .pat_mask(pat_mask),
    .overlap_en(overlap_en), .count_clr(count_clr),
    .armed(armed8), .outFlag(flag8), .match_count(cnt8), .count_sat(sat8)
  );

  seq_detect_param #(.PAT_W(4), .CNT_W(2)) u2 (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .pat_load(pat_load), .pat_in(pat_in), .pat_mask(pat_mask),
    .overlap_en(overlap_en), .count_clr(count_clr),
    .armed(armed2), .outFlag(flag2), .match_count(cnt2), .count_sat(sat2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic flag;
    logic armed;
    int   c8;
    int   c2;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int         m_state;   // 0 idle, 1 fill, 2 hunt
  logic [3:0] m_win;
  int         m_fill;
  logic [3:0] m_pat;
  logic [3:0] m_mask;
  int         m_c8;
  int         m_c2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic rst_n, input logic ld, input logic v, input logic b,
                      input logic ov, input logic clr);
    exp_t e;
    logic m;
    reset      = rst_n;
    pat_load   = ld;
    bit_valid  = v;
    bit_in     = b;
    overlap_en = ov;
    count_clr  = clr;
    m = 1'b0;
    if (!rst_n) begin
      m_state = 0; m_win = '0; m_fill = 0; m_pat = '0; m_mask = '0;
      m_c8 = 0; m_c2 = 0;
    end else begin
      if (ld) begin
        m_pat = pat_in; m_mask = pat_mask; m_win = '0; m_fill = 0; m_state = 1;
      end else if (v && m_state != 0) begin
        m_win = {m_win[2:0], b};
        if (m_state == 1) m_fill++;
        if (m_state == 2 || m_fill == 4)
          m = ((~(m_win ^ m_pat)) & m_mask) == m_mask;
        if (m_state == 1 && m_fill == 4) m_state = 2;
        if (m && !ov) begin
          m_state = 1; m_fill = 0;
        end
      end
      if (clr) begin
        m_c8 = 0; m_c2 = 0;
      end else if (m) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
      end
    end
    e.flag = m; e.armed = (m_state != 0); e.c8 = m_c8; e.c2 = m_c2;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk("outFlag8", {31'd0, flag8}, {31'd0, e.flag});
    chk("outFlag2", {31'd0, flag2}, {31'd0, e.flag});
    chk("armed8", {31'd0, armed8}, {31'd0, e.armed});
    chk("armed2", {31'd0, armed2}, {31'd0, e.armed});
    chk("count8", {24'd0, cnt8}, e.c8);
    chk("count2", {30'd0, cnt2}, e.c2);
    chk("sat8", {31'd0, sat8}, {31'd0, (e.c8 == 255)});
    chk("sat2", {31'd0, sat2}, {31'd0, (e.c2 == 3)});
    $display("step rst=%b ld=%b v=%b b=%b ov=%b clr=%b -> flag=%b armed=%b cnt8=%0d cnt2=%0d sat2=%b",
             rst_n, ld, v, b, ov, clr, flag8, armed8, cnt8, cnt2, sat2);
  endtask

  task automatic stream(input logic [15:0] bits, input int n, input logic ov, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, 1'b0, 1'b1, bits[i], ov, 1'b0);
      for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 1'b0, 1'b0, ov, 1'b0);
    end
  endtask

  task automatic load(input logic [3:0] p, input logic [3:0] mk, input logic ov);
    pat_in = p; pat_mask = mk;
    step(1'b1, 1'b1, 1'b0, 1'b0, ov, 1'b0);
  endtask

  initial begin
    reset = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; pat_load = 1'b0;
    pat_in = '0; pat_mask = '0; overlap_en = 1'b0; count_clr = 1'b0;
    m_state = 0; m_win = '0; m_fill = 0; m_pat = '0; m_mask = '0; m_c8 = 0; m_c2 = 0;
    @(negedge clock);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_armed", {31'd0, armed8}, 32'd0);
    chk("reset_count", {24'd0, cnt8}, 32'd0);

    // 1: reset mid-stream, then bits while idle are ignored
    load(4'b1101, 4'b1111, 1'b1);
    stream(16'b110, 3, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("midreset_armed", {31'd0, armed8}, 32'd0);
    chk("midreset_flag", {31'd0, flag8}, 32'd0);
    stream(16'b1101, 4, 1'b1, 0);
    chk("idle_flag", {31'd0, flag8}, 32'd0);

    // 2: overlapping
    load(4'b1101, 4'b1111, 1'b1);
    stream(16'b110, 3, 1'b1, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("ov_first_pulse", {31'd0, flag8}, 32'd1);
    stream(16'b101, 3, 1'b1, 0);
    chk("ov_second_pulse", {31'd0, flag8}, 32'd1);
    chk("ov_count", {24'd0, cnt8}, 32'd2);

    // 3: non-overlapping
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    load(4'b1101, 4'b1111, 1'b0);
    stream(16'b1101101, 7, 1'b0, 0);
    chk("nov_no_second", {31'd0, flag8}, 32'd0);
    chk("nov_count", {24'd0, cnt8}, 32'd1);
    stream(16'b101101, 6, 1'b0, 0);
    chk("nov_count_after", {24'd0, cnt8}, 32'd2);

    // 4: don't-care mask, then gaps between valid bits
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    load(4'b1101, 4'b1011, 1'b1);
    stream(16'b1001, 4, 1'b1, 0);
    chk("mask_match", {31'd0, flag8}, 32'd1);
    load(4'b1101, 4'b1011, 1'b1);
    stream(16'b0101, 4, 1'b1, 0);
    chk("mask_nomatch", {31'd0, flag8}, 32'd0);
    load(4'b1101, 4'b1011, 1'b1);
    stream(16'b100, 3, 1'b1, 3);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("gap_match", {31'd0, flag8}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("gap_pulse_one_cycle", {31'd0, flag8}, 32'd0);

    // 5: saturation on the 2-bit counter, clear on a matching edge
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    load(4'b1111, 4'b1111, 1'b1);
    stream(16'hFF, 8, 1'b1, 0);
    chk("sat_count2", {30'd0, cnt2}, 32'd3);
    chk("sat_flag2", {31'd0, sat2}, 32'd1);
    chk("sat_count8", {24'd0, cnt8}, 32'd5);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_flag", {31'd0, flag2}, 32'd1);
    chk("clr_count2", {30'd0, cnt2}, 32'd0);
    chk("clr_sat2", {31'd0, sat2}, 32'd0);

    // 6: load on the 3rd bit drops it and restarts the fill
    load(4'b1101, 4'b1111, 1'b1);
    stream(16'b11, 2, 1'b1, 0);
    pat_in = 4'b1101; pat_mask = 4'b1111;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("reload_flag", {31'd0, flag8}, 32'd0);
    stream(16'b110, 3, 1'b1, 0);
    chk("reload_early", {31'd0, flag8}, 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("reload_match", {31'd0, flag8}, 32'd1);
    chk("reload_count", {24'd0, cnt8}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 4-bit Moore sequence detectors in the assignment set.
- Pattern width is a parameter. Pattern and don't-care mask are runtime-loadable.
- Input is qualified by a valid strobe. Overlapping or non-overlapping match mode is selectable, and a saturating match counter is provided.
- Sits on a serial bit stream; outFlag feeds downstream framing/event logic.

Parameters:
- PAT_W, 4, pattern length in bits (≥2).
- CNT_W, 8, width of match counter.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- bit_in  input  1  serial data bit
- bit_valid  input  1  bit_in is sampled only when 1
- pat_load  input  1  load pat_in/pat_mask, restart search
- pat_in  input  PAT_W  pattern; bit PAT_W-1 = first (oldest) bit received, bit 0 = last
- pat_mask  input  PAT_W  1 = compare bit, 0 = don't care
- overlap_en  input  1  1 = overlapping matches allowed
- count_clr  input  1  clear match counter
- armed  output  1  pattern loaded (state ≠ IDLE)
- outFlag  output  1  one-cycle match pulse
- match_count  output  CNT_W  saturating number of matches
- count_sat  output  1  match_count at all-ones

Behaviour:
- Clock and reset:
  - Single clock. All state updates on the rising edge of clock.
  - reset is synchronous and active-low.
- Reset (reset=0 at an edge):
  - state=IDLE, window=0, fill=0, pattern=0, mask=0.
  - outFlag=0, match_count=0, count_sat=0, armed=0.
  - Reset has priority over all inputs, including mid-fill or mid-match.
- State machine:
  - IDLE: nothing loaded; bits are ignored; outFlag stays 0.
    - pat_load=1 → FILL.
  - FILL: window holds fewer than PAT_W valid bits since load/restart.
    - Each bit_valid edge shifts: window = {window[PAT_W-2:0], bit_in}, fill+1.
    - When fill reaches PAT_W on a shift → HUNT. The match is evaluated on that same shift.
  - HUNT: window is full.
    - Each bit_valid edge shifts and evaluates a match.
- Match condition: ((new_window XNOR pattern) AND mask) has all mask bits set.
  - Evaluated only on a shift that completes ≥PAT_W bits.
  - A mask of all zeros matches on every full window.
- On a match:
  - outFlag=1 for exactly the next cycle (registered; latency 1 clock from the edge sampling the last pattern bit).
  - match_count increments unless already all-ones.
  - overlap_en=1: stay in HUNT; the window is kept.
  - overlap_en=0: go to FILL with fill=0. The next match needs PAT_W fresh bits.
- outFlag is 0 in every cycle not directly following a matching shift. bit_valid=0 leaves the window, fill and state unchanged.
- pat_load=1 (any state except during reset):
  - Latch pat_in and pat_mask.
  - Clear window and fill; state=FILL.
  - bit_in in that cycle is discarded; no match is evaluated; outFlag=0 next cycle.
  - match_count is unaffected.
- count_clr=1: match_count=0 and count_sat=0 next cycle.
  - If a match occurs in the same cycle, clear wins (count=0), but outFlag still pulses.
- count_sat = (match_count == all-ones), registered alongside match_count.
- overlap_en is sampled only at the match edge. Changing it has no other effect.

Test Plan:
1. Reset mid-stream (reset=0 one edge) after some bits → armed=0, outFlag=0, match_count=0; stream 1101 while IDLE → no outFlag.
2. Load pat_in=4'b1101, mask=4'b1111, overlap_en=1; stream 1,1,0,1,1,0,1 (bit_valid=1) → outFlag pulses in the cycle after the 4th and after the 7th bit; match_count=2.
3. Same load with overlap_en=0, same stream → single pulse after the 4th bit, none after the 7th; match_count=1; the further bits 1,0,1,1,0,1 give a pulse after the 10th bit (fill restarted at 0 after the 4th, so the 4-bit window over bits 7–10 is 1101).
4. pat_in=4'b1101, mask=4'b1011; stream 1,0,0,1 → match (bit 2 is don't care); stream 0,1,0,1 → no match; insert bit_valid=0 gaps of 3 cycles between bits → identical result, with outFlag timing tied to the last valid bit.
5. CNT_W=2, overlap_en=1, pattern 4'b1111, stream eight 1s → 5 matches, match_count=3, count_sat=1; assert count_clr on a matching edge → outFlag=1, match_count=0, count_sat=0.
6. pat_load asserted on the edge of the 3rd bit of 1101 → that bit is dropped, fill=0; the next 1101 matches after its 4th bit only.
